// File: rtl/rs_if.sv
// Bundles the reservation station's dispatch, CDB, flush and ALU-issue signals.
// The master side is the surrounding pipeline; the slave side is the station.
interface rs_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
);
    logic             rdy;
    logic [ROB_W-1:0] in_dcd_rob_tag;
    logic [OP_W-1:0]  in_dcd_op;
    logic [31:0]      in_dcd_value1;
    logic [31:0]      in_dcd_value2;
    logic [ROB_W-1:0] in_dcd_tag1;
    logic [ROB_W-1:0] in_dcd_tag2;
    logic [31:0]      in_dcd_imm;
    logic [31:0]      in_dcd_pc;
    logic [ROB_W-1:0] in_alu_cdb_tag;
    logic [31:0]      in_alu_cdb_value;
    logic [ROB_W-1:0] in_lsb_cdb_tag;
    logic [31:0]      in_lsb_cdb_value;
    logic             in_rob_flush;
    logic             out_full;
    logic [ROB_W-1:0] out_alu_rob_tag;
    logic [OP_W-1:0]  out_alu_op;
    logic [31:0]      out_alu_value1;
    logic [31:0]      out_alu_value2;
    logic [31:0]      out_alu_imm;
    logic [31:0]      out_alu_pc;

    modport master (
        output rdy, in_dcd_rob_tag, in_dcd_op, in_dcd_value1, in_dcd_value2,
               in_dcd_tag1, in_dcd_tag2, in_dcd_imm, in_dcd_pc,
               in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
               in_rob_flush,
        input  out_full, out_alu_rob_tag, out_alu_op, out_alu_value1,
               out_alu_value2, out_alu_imm, out_alu_pc
    );

    modport slave (
        input  rdy, in_dcd_rob_tag, in_dcd_op, in_dcd_value1, in_dcd_value2,
               in_dcd_tag1, in_dcd_tag2, in_dcd_imm, in_dcd_pc,
               in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
               in_rob_flush,
        output out_full, out_alu_rob_tag, out_alu_op, out_alu_value1,
               out_alu_value2, out_alu_imm, out_alu_pc
    );
endinterface

// File: rtl/rs_station.sv
// Reservation station: holds dispatched ALU ops until both operands arrive on
// the CDBs, then issues the lowest-index ready entry, one per cycle.
module rs_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input logic clk,
    input logic rst,
    rs_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic             busy    [RS_SIZE];
    logic [OP_W-1:0]  op      [RS_SIZE];
    logic [ROB_W-1:0] rob_tag [RS_SIZE];
    logic [31:0]      value1  [RS_SIZE];
    logic [31:0]      value2  [RS_SIZE];
    logic [ROB_W-1:0] tag1    [RS_SIZE];
    logic [ROB_W-1:0] tag2    [RS_SIZE];
    logic [31:0]      imm     [RS_SIZE];
    logic [31:0]      pc      [RS_SIZE];

    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic             free_valid;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic [ROB_W-1:0] disp_tag1, disp_tag2;
    logic [31:0]      disp_value1, disp_value2;

    // Scanning downward leaves the lowest matching index selected.
    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        free_valid  = 1'b0;
        free_idx    = '0;
        busy_cnt    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy[i] && tag1[i] == '0 && tag2[i] == '0) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i]) busy_cnt = busy_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        disp_tag1   = bus.in_dcd_tag1;
        disp_value1 = bus.in_dcd_value1;
        disp_tag2   = bus.in_dcd_tag2;
        disp_value2 = bus.in_dcd_value2;
        if (bus.in_dcd_tag1 != '0 && bus.in_dcd_tag1 == bus.in_alu_cdb_tag) begin
            disp_tag1   = '0;
            disp_value1 = bus.in_alu_cdb_value;
        end else if (bus.in_dcd_tag1 != '0 && bus.in_dcd_tag1 == bus.in_lsb_cdb_tag) begin
            disp_tag1   = '0;
            disp_value1 = bus.in_lsb_cdb_value;
        end
        if (bus.in_dcd_tag2 != '0 && bus.in_dcd_tag2 == bus.in_alu_cdb_tag) begin
            disp_tag2   = '0;
            disp_value2 = bus.in_alu_cdb_value;
        end else if (bus.in_dcd_tag2 != '0 && bus.in_dcd_tag2 == bus.in_lsb_cdb_tag) begin
            disp_tag2   = '0;
            disp_value2 = bus.in_lsb_cdb_value;
        end
    end

    assign bus.out_full = (busy_cnt >= CNT_W'(RS_SIZE - 1));

    always_ff @(posedge clk) begin
        bus.out_alu_rob_tag <= '0;
        bus.out_alu_op      <= '0;
        bus.out_alu_value1  <= '0;
        bus.out_alu_value2  <= '0;
        bus.out_alu_imm     <= '0;
        bus.out_alu_pc      <= '0;
        if (!rst || (bus.in_rob_flush && bus.rdy)) begin
            for (int i = 0; i < RS_SIZE; i++) busy[i] <= 1'b0;
        end else if (bus.rdy) begin
            if (issue_valid) begin
                bus.out_alu_rob_tag <= rob_tag[issue_idx];
                bus.out_alu_op      <= op[issue_idx];
                bus.out_alu_value1  <= value1[issue_idx];
                bus.out_alu_value2  <= value2[issue_idx];
                bus.out_alu_imm     <= imm[issue_idx];
                bus.out_alu_pc      <= pc[issue_idx];
                busy[issue_idx]     <= 1'b0;
            end
            // Waiting entries never collide with the free slot the dispatch writes.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (tag1[i] != '0 && tag1[i] == bus.in_alu_cdb_tag) begin
                        value1[i] <= bus.in_alu_cdb_value;
                        tag1[i]   <= '0;
                    end else if (tag1[i] != '0 && tag1[i] == bus.in_lsb_cdb_tag) begin
                        value1[i] <= bus.in_lsb_cdb_value;
                        tag1[i]   <= '0;
                    end
                    if (tag2[i] != '0 && tag2[i] == bus.in_alu_cdb_tag) begin
                        value2[i] <= bus.in_alu_cdb_value;
                        tag2[i]   <= '0;
                    end else if (tag2[i] != '0 && tag2[i] == bus.in_lsb_cdb_tag) begin
                        value2[i] <= bus.in_lsb_cdb_value;
                        tag2[i]   <= '0;
                    end
                end
            end
            if (bus.in_dcd_rob_tag != '0 && free_valid) begin
                busy[free_idx]    <= 1'b1;
                op[free_idx]      <= bus.in_dcd_op;
                rob_tag[free_idx] <= bus.in_dcd_rob_tag;
                value1[free_idx]  <= disp_value1;
                value2[free_idx]  <= disp_value2;
                tag1[free_idx]    <= disp_tag1;
                tag2[free_idx]    <= disp_tag2;
                imm[free_idx]     <= bus.in_dcd_imm;
                pc[free_idx]      <= bus.in_dcd_pc;
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: dispatch, wake-up, bypass, fill, flush and freeze
// with hand-computed expected issue values.
module tb_rs_station;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rs_if #(.ROB_W(4), .OP_W(6)) bus ();

    rs_station #(.RS_SIZE(16), .ROB_W(4), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dispatching into a full station is a protocol violation by the pipeline.
    always @(posedge clk) begin
        if (rst && bus.rdy && !bus.in_rob_flush && bus.in_dcd_rob_tag != '0)
            assert (dut.free_valid) else $error("[TB] dispatch with no free entry");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clearInputs();
        bus.rdy              = 1'b1;
        bus.in_dcd_rob_tag   = '0;
        bus.in_dcd_op        = '0;
        bus.in_dcd_value1    = '0;
        bus.in_dcd_value2    = '0;
        bus.in_dcd_tag1      = '0;
        bus.in_dcd_tag2      = '0;
        bus.in_dcd_imm       = '0;
        bus.in_dcd_pc        = '0;
        bus.in_alu_cdb_tag   = '0;
        bus.in_alu_cdb_value = '0;
        bus.in_lsb_cdb_tag   = '0;
        bus.in_lsb_cdb_value = '0;
        bus.in_rob_flush     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] tag, input logic [5:0] opc,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [3:0] t1, input logic [3:0] t2);
        bus.in_dcd_rob_tag = tag;
        bus.in_dcd_op      = opc;
        bus.in_dcd_value1  = v1;
        bus.in_dcd_value2  = v2;
        bus.in_dcd_tag1    = t1;
        bus.in_dcd_tag2    = t2;
        bus.in_dcd_imm     = 32'h100 + 32'(tag);
        bus.in_dcd_pc      = 32'h4000 + 32'(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearInputs();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("reset_tag", 32'(bus.out_alu_rob_tag), 32'h0);
        checkOutput("reset_op", 32'(bus.out_alu_op), 32'h0);
        checkOutput("reset_v1", bus.out_alu_value1, 32'h0);
        checkOutput("reset_full", 32'(bus.out_full), 32'h0);
        rst = 1'b1;
        tick();

        // Ready dispatch issues one edge later, for one cycle only.
        applyStimulus(4'd3, 6'd1, 32'd5, 32'd7, 4'd0, 4'd0);
        tick();
        clearInputs();
        checkOutput("ready_not_yet", 32'(bus.out_alu_rob_tag), 32'h0);
        tick();
        checkOutput("ready_tag", 32'(bus.out_alu_rob_tag), 32'd3);
        checkOutput("ready_op", 32'(bus.out_alu_op), 32'd1);
        checkOutput("ready_v1", bus.out_alu_value1, 32'd5);
        checkOutput("ready_v2", bus.out_alu_value2, 32'd7);
        checkOutput("ready_imm", bus.out_alu_imm, 32'h103);
        checkOutput("ready_pc", bus.out_alu_pc, 32'h4003);
        tick();
        checkOutput("ready_once", 32'(bus.out_alu_rob_tag), 32'h0);

        // Single operand wake-up from the ALU CDB.
        applyStimulus(4'd4, 6'd2, 32'h999, 32'd10, 4'd2, 4'd0);
        tick();
        clearInputs();
        tick();
        checkOutput("wake_wait", 32'(bus.out_alu_rob_tag), 32'h0);
        bus.in_alu_cdb_tag   = 4'd2;
        bus.in_alu_cdb_value = 32'h55;
        tick();
        clearInputs();
        checkOutput("wake_edge", 32'(bus.out_alu_rob_tag), 32'h0);
        tick();
        checkOutput("wake_tag", 32'(bus.out_alu_rob_tag), 32'd4);
        checkOutput("wake_v1", bus.out_alu_value1, 32'h55);
        checkOutput("wake_v2", bus.out_alu_value2, 32'd10);

        // Both operands woken in the same cycle from different buses.
        applyStimulus(4'd6, 6'd3, 32'h0, 32'h0, 4'd7, 4'd8);
        tick();
        clearInputs();
        bus.in_lsb_cdb_tag   = 4'd7;
        bus.in_lsb_cdb_value = 32'h11;
        bus.in_alu_cdb_tag   = 4'd8;
        bus.in_alu_cdb_value = 32'h22;
        tick();
        clearInputs();
        checkOutput("dual_edge", 32'(bus.out_alu_rob_tag), 32'h0);
        tick();
        checkOutput("dual_tag", 32'(bus.out_alu_rob_tag), 32'd6);
        checkOutput("dual_v1", bus.out_alu_value1, 32'h11);
        checkOutput("dual_v2", bus.out_alu_value2, 32'h22);

        // Dispatch bypass from the LSB CDB.
        applyStimulus(4'd5, 6'd4, 32'h0, 32'd3, 4'd1, 4'd0);
        bus.in_lsb_cdb_tag   = 4'd1;
        bus.in_lsb_cdb_value = 32'hAB;
        tick();
        clearInputs();
        tick();
        checkOutput("bypass_tag", 32'(bus.out_alu_rob_tag), 32'd5);
        checkOutput("bypass_v1", bus.out_alu_value1, 32'hAB);
        tick();

        // Fill 15 entries blocked on tag 9, then release them all at once.
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(4'(i), 6'd1, 32'h0, 32'(i * 16), 4'd9, 4'd0);
            tick();
            if (i == 14) checkOutput("fill_14_full", 32'(bus.out_full), 32'h0);
        end
        clearInputs();
        checkOutput("fill_15_full", 32'(bus.out_full), 32'h1);
        checkOutput("fill_no_issue", 32'(bus.out_alu_rob_tag), 32'h0);
        bus.in_alu_cdb_tag   = 4'd9;
        bus.in_alu_cdb_value = 32'h99;
        tick();
        clearInputs();
        checkOutput("fill_wake_full", 32'(bus.out_full), 32'h1);
        for (int j = 1; j <= 15; j++) begin
            tick();
            checkOutput($sformatf("drain_tag_%0d", j), 32'(bus.out_alu_rob_tag), 32'(j));
            checkOutput($sformatf("drain_v2_%0d", j), bus.out_alu_value2, 32'(j * 16));
            if (j == 1) checkOutput("drain_full_drop", 32'(bus.out_full), 32'h0);
        end
        checkOutput("drain_v1_last", bus.out_alu_value1, 32'h99);
        tick();
        checkOutput("drain_done", 32'(bus.out_alu_rob_tag), 32'h0);

        // Flush with four waiting entries and a concurrent dispatch.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(4'(i), 6'd1, 32'h0, 32'h0, 4'd3, 4'd0);
            tick();
        end
        applyStimulus(4'd10, 6'd1, 32'd1, 32'd2, 4'd0, 4'd0);
        bus.in_rob_flush = 1'b1;
        tick();
        clearInputs();
        checkOutput("flush_tag", 32'(bus.out_alu_rob_tag), 32'h0);
        bus.in_alu_cdb_tag   = 4'd3;
        bus.in_alu_cdb_value = 32'h33;
        tick();
        clearInputs();
        checkOutput("flush_after1", 32'(bus.out_alu_rob_tag), 32'h0);
        tick();
        checkOutput("flush_after2", 32'(bus.out_alu_rob_tag), 32'h0);

        // Flush cancels an issue that would otherwise happen on that edge.
        applyStimulus(4'd12, 6'd1, 32'd1, 32'd2, 4'd0, 4'd0);
        tick();
        clearInputs();
        bus.in_rob_flush = 1'b1;
        tick();
        clearInputs();
        checkOutput("flush_cancel", 32'(bus.out_alu_rob_tag), 32'h0);
        tick();
        checkOutput("flush_cancel2", 32'(bus.out_alu_rob_tag), 32'h0);

        // Freeze holds a ready entry; dispatch during freeze is ignored.
        applyStimulus(4'd7, 6'd3, 32'h1234, 32'h5678, 4'd0, 4'd0);
        tick();
        clearInputs();
        bus.rdy = 1'b0;
        applyStimulus(4'd11, 6'd2, 32'hDEAD, 32'hBEEF, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("freeze_%0d", k), 32'(bus.out_alu_rob_tag), 32'h0);
        end
        clearInputs();
        tick();
        checkOutput("thaw_tag", 32'(bus.out_alu_rob_tag), 32'd7);
        checkOutput("thaw_op", 32'(bus.out_alu_op), 32'd3);
        checkOutput("thaw_v1", bus.out_alu_value1, 32'h1234);
        checkOutput("thaw_v2", bus.out_alu_value2, 32'h5678);
        tick();
        checkOutput("thaw_drop", 32'(bus.out_alu_rob_tag), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_station.md
# rs_station

Reservation station between the decoder's RS dispatch port and the ALU. Every cycle it accepts at most one dispatched entry, holds it until both source operands are valid, and captures missing operands from the ALU and LSB common data buses. It then issues one ready entry per cycle to the ALU. A ROB misprediction flush empties it.

## Interface
- RS_SIZE, 16: number of entries (power of two, ≥4)
- ROB_W, 4: ROB tag width; tag 0 means "no tag / operand valid"
- OP_W, 6: operation enum width; 0 = NOP
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-low
- rdy  in  1  global ready; low = freeze
- in_dcd_rob_tag  in  ROB_W  dispatch ROB tag; nonzero = dispatch valid this cycle
- in_dcd_op  in  OP_W  operation enum
- in_dcd_value1, in_dcd_value2  in  32  operand values, meaningful when matching tag = 0
- in_dcd_tag1, in_dcd_tag2  in  ROB_W  producer tags, 0 = operand ready
- in_dcd_imm, in_dcd_pc  in  32  immediate, instruction PC
- in_alu_cdb_tag, in_lsb_cdb_tag  in  ROB_W  CDB broadcast tags, 0 = no broadcast
- in_alu_cdb_value, in_lsb_cdb_value  in  32  CDB results
- in_rob_flush  in  1  misprediction flush
- out_full  out  1  fewer than 2 free entries; fetcher stops dispatching
- out_alu_rob_tag  out  ROB_W  issued entry tag, 0 = no issue
- out_alu_op  out  OP_W;  out_alu_value1, out_alu_value2, out_alu_imm, out_alu_pc  out  32  issued operands

## Operation
- Entry state: busy, op, rob_tag, value1/2, tag1/2, imm, pc. Ready = busy && tag1==0 && tag2==0.
- Dispatch: when in_dcd_rob_tag≠0, write into the lowest-index non-busy entry. Free-entry selection uses the pre-edge busy vector. A slot issued on the same edge is not reused until the next cycle.
- Dispatch bypass: if an incoming tagN≠0 equals a nonzero CDB tag in the same cycle, store that CDB value with tagN=0. ALU CDB is checked first; the two CDB tags are never equal.
- Wake-up: for every busy entry and each operand with tagN≠0 matching a CDB tag, latch the value and clear tagN.
- Issue select: the lowest-index ready entry, evaluated on registered state. Drive its fields onto the out_alu_* registers and clear busy. With no ready entry, out_alu_rob_tag=0 and the other outputs = 0.
- out_full: combinational from the registered busy count; = 1 when free entries ≤ 1.
- Dispatch with no free entry is a protocol violation. The bench asserts it never happens; RTL drops the entry.
- Flush (in_rob_flush=1, rdy=1): clear all busy and out_alu_rob_tag; ignore that cycle's dispatch and CDB.
- rdy=0: all entries and tags hold, dispatch and CDB are ignored, and out_alu_rob_tag is driven 0 (nothing is lost).
- Priority per edge: rst > flush > rdy freeze > {dispatch, wake-up, issue} concurrently.

## Timing
- Reset (rst=0 at edge): all busy=0; out_alu_rob_tag=0, out_alu_op=0, all out_alu_* data=0; out_full=0.
- Dispatch of an entry with both tags 0 at edge N: the entry is issued at edge N+1, visible on out_alu_* after N+1 (1-cycle latency).
- Wake-up of the last pending operand at edge N: the entry is issued at edge N+1.
- Dispatch-bypassed operand: same as dispatch of a ready entry.
- Issue bandwidth: 1 per cycle. Outputs are registered and valid for exactly one cycle per issue.
- Flush mid-cycle with a pending issue: the issue is cancelled; outputs after the edge have tag 0.

## Test plan
- Reset then idle: rst=0 for 2 cycles → out_alu_rob_tag=0, out_full=0. Dispatch tag 3, ADD, v1=5, v2=7, tags 0 → next cycle out_alu_rob_tag=3, value1=5, value2=7, then 0.
- Wake-up: dispatch tag 4, tag1=2, value2=10. Two cycles later ALU CDB (2, 0x55) → entry issues the next cycle with value1=0x55, value2=10. Also a dual wake where tag1 matches LSB CDB and tag2 matches ALU CDB in the same cycle.
- Bypass: dispatch tag 5, tag1=1 while LSB CDB tag=1, value 0xAB → issue next cycle with value1=0xAB.
- Fill: dispatch 15 blocked entries (tag1=9) → out_full=1 once 15 are busy. Broadcast tag 9 → entries issue in index order, one per cycle, over 15 cycles. out_full drops when free ≥ 2.
- Flush: 4 busy entries, in_rob_flush=1 together with a dispatch → all cleared, dispatch ignored, out_alu_rob_tag=0. A later CDB matching the old tags issues nothing.
- Freeze: ready entry present, rdy=0 for 3 cycles → out_alu_rob_tag=0 throughout. When rdy returns to 1, the entry issues with the original values.
